// File: rtl/wr_ptr_ctrl.sv
// Write-domain pointer and flag controller for the async FIFO: binary/Gray write
// pointers, optional read-pointer synchroniser, exact fill level and registered flags.
module wr_ptr_ctrl #(
  parameter int PTR_SIZE     = 4,
  parameter int AFULL_THRESH = 12,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                wr_clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [PTR_SIZE:0]   g_rptr_in,
  input  logic                ovf_clr,
  output logic                full,
  output logic                almost_full,
  output logic                overflow,
  output logic                wr_ack,
  output logic [PTR_SIZE:0]   wr_level,
  output logic [PTR_SIZE-1:0] waddr,
  output logic [PTR_SIZE:0]   b_wptr,
  output logic [PTR_SIZE:0]   g_wptr
);

  localparam int              PW      = PTR_SIZE + 1;
  localparam logic [PTR_SIZE:0] DEPTH_L = PW'(2 ** PTR_SIZE);
  localparam logic [PTR_SIZE:0] AFULL_L = PW'(AFULL_THRESH);

  function automatic logic [PTR_SIZE:0] bin2gray(input logic [PTR_SIZE:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PTR_SIZE:0] gray2bin(input logic [PTR_SIZE:0] g);
    logic [PTR_SIZE:0] b;
    b[PTR_SIZE] = g[PTR_SIZE];
    for (int i = PTR_SIZE - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [PTR_SIZE:0] rptr_s;
  logic [PTR_SIZE:0] b_rptr;
  logic [PTR_SIZE:0] b_next;
  logic [PTR_SIZE:0] g_next;
  logic [PTR_SIZE:0] level_next;
  logic              push;

  // Read-pointer synchroniser stages (bypassed when the pointer arrives pre-synced)
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign rptr_s = g_rptr_in;
    end else begin : g_sync
      logic [PTR_SIZE:0] sync_p [SYNC_STAGES];
      always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < SYNC_STAGES; i++) sync_p[i] <= '0;
        end else begin
          sync_p[0] <= g_rptr_in;
          for (int i = 1; i < SYNC_STAGES; i++) sync_p[i] <= sync_p[i-1];
        end
      end
      assign rptr_s = sync_p[SYNC_STAGES-1];
    end
  endgenerate

  always_comb begin
    push       = wr_en & ~full;
    b_next     = b_wptr + {{PTR_SIZE{1'b0}}, push};
    g_next     = bin2gray(b_next);
    b_rptr     = gray2bin(rptr_s);
    level_next = b_next - b_rptr;
  end

  // Pointer and flag registers; the level already includes this edge's push
  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      b_wptr      <= '0;
      g_wptr      <= '0;
      wr_level    <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
      wr_ack      <= 1'b0;
    end else begin
      b_wptr      <= b_next;
      g_wptr      <= g_next;
      wr_level    <= level_next;
      full        <= (level_next == DEPTH_L);
      almost_full <= (level_next >= AFULL_L);
      overflow    <= (wr_en & full) | (overflow & ~ovf_clr);
      wr_ack      <= push;
    end
  end

  assign waddr = b_wptr[PTR_SIZE-1:0];

endmodule

// File: tb/tb_wr_ptr_ctrl.sv
// Bench for wr_ptr_ctrl: directed scenarios plus random traffic against a
// counter-based FIFO occupancy model with a delayed view of the read pointer.
module tb_wr_ptr_ctrl;

  logic       wr_clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic       ovf_clr = 1'b0;
  logic [4:0] g_rptr_in;
  logic       full, almost_full, overflow, wr_ack;
  logic [4:0] wr_level, b_wptr, g_wptr;
  logic [3:0] waddr;

  logic [4:0] rd_bin = '0;
  assign g_rptr_in = rd_bin ^ (rd_bin >> 1);

  int total = 0;
  int bad   = 0;

  // model: write count, two-edge delayed view of the read count, flags
  int m_wp, m_s0, m_s1, m_level;
  bit m_full, m_af, m_ovf, m_ack;
  logic [4:0] prev_g;

  wr_ptr_ctrl #(.PTR_SIZE(4), .AFULL_THRESH(12), .SYNC_STAGES(2)) dut (
    .wr_clk(wr_clk), .rst(rst), .wr_en(wr_en), .g_rptr_in(g_rptr_in),
    .ovf_clr(ovf_clr), .full(full), .almost_full(almost_full),
    .overflow(overflow), .wr_ack(wr_ack), .wr_level(wr_level),
    .waddr(waddr), .b_wptr(b_wptr), .g_wptr(g_wptr)
  );

  always #5 wr_clk = ~wr_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_wp = 0; m_s0 = 0; m_s1 = 0; m_level = 0;
    m_full = 0; m_af = 0; m_ovf = 0; m_ack = 0;
    prev_g = '0;
  endtask

  task automatic model_edge(input bit we, input bit clr);
    bit push;
    int wn, lv;
    if (rst) begin
      model_reset();
      return;
    end
    push    = we && !m_full;
    wn      = (m_wp + int'(push)) & 31;
    lv      = (wn - m_s1) & 31;
    m_ovf   = (we && m_full) || (m_ovf && !clr);
    m_full  = (lv == 16);
    m_af    = (lv >= 12);
    m_ack   = push;
    m_level = lv;
    m_wp    = wn;
    m_s1    = m_s0;
    m_s0    = int'(rd_bin);
  endtask

  task automatic check_all();
    chk("b_wptr", b_wptr, m_wp);
    chk("g_wptr", g_wptr, m_wp ^ (m_wp >> 1));
    chk("waddr", waddr, m_wp & 15);
    chk("wr_level", wr_level, m_level);
    chk("full", full, m_full);
    chk("almost_full", almost_full, m_af);
    chk("overflow", overflow, m_ovf);
    chk("wr_ack", wr_ack, m_ack);
    chk("g_onebit", ($countones(g_wptr ^ prev_g) <= 1), 1);
    prev_g = g_wptr;
  endtask

  task automatic step(input bit we, input bit clr);
    wr_en   = we;
    ovf_clr = clr;
    @(posedge wr_clk);
    model_edge(we, clr);
    #1;
    check_all();
  endtask

  initial begin
    model_reset();
    // power-on reset
    #2 rst = 1'b1;
    #2 check_all();
    step(1, 0);
    step(1, 0);
    rst = 1'b0;

    // reset asserted in the middle of a write burst
    for (int i = 0; i < 5; i++) step(1, 0);
    chk("pre_rst_wptr", b_wptr, 5);
    @(negedge wr_clk);
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    step(1, 0);
    rst = 1'b0;

    // fill from empty
    for (int i = 1; i <= 16; i++) begin
      step(1, 0);
      chk("fill_level", wr_level, i);
      if (i == 11) chk("af_before_12", almost_full, 0);
      if (i == 12) chk("af_at_12", almost_full, 1);
      if (i == 15) chk("full_before_16", full, 0);
    end
    chk("fill_full", full, 1);
    chk("fill_ack", wr_ack, 1);
    chk("fill_gray", g_wptr, 5'b11000);
    chk("fill_waddr", waddr, 0);

    // writes while full are dropped and flag overflow
    for (int i = 0; i < 3; i++) step(1, 0);
    chk("ovf_set", overflow, 1);
    chk("ovf_wptr", b_wptr, 16);
    chk("ovf_ack", wr_ack, 0);
    step(1, 1);
    chk("ovf_set_wins", overflow, 1);
    step(0, 1);
    chk("ovf_cleared", overflow, 0);

    // drain of one entry becomes visible three edges later
    rd_bin = 5'd1;
    step(0, 0);
    step(0, 0);
    chk("drain_still_full", full, 1);
    step(0, 0);
    chk("drain_full", full, 0);
    chk("drain_level", wr_level, 15);

    // advance both pointers to 31, then wrap
    while (m_wp != 31) begin
      rd_bin = 5'(m_wp);
      step(1, 0);
    end
    rd_bin = 5'd31;
    for (int i = 0; i < 3; i++) step(0, 0);
    chk("wrap_empty", wr_level, 0);
    step(1, 0);
    chk("wrap_wptr0", b_wptr, 0);
    chk("wrap_lvl1", wr_level, 1);
    step(1, 0);
    chk("wrap_wptr1", b_wptr, 1);
    chk("wrap_lvl2", wr_level, 2);
    chk("wrap_nofull", full, 0);

    // build level 10, then write and read one per cycle
    rd_bin = 5'(m_wp);
    for (int i = 0; i < 3; i++) step(0, 0);
    for (int i = 0; i < 10; i++) step(1, 0);
    chk("conc_start", wr_level, 10);
    rd_bin = rd_bin + 5'd1;
    step(0, 0);
    rd_bin = rd_bin + 5'd1;
    step(0, 0);
    for (int i = 0; i < 12; i++) begin
      rd_bin = rd_bin + 5'd1;
      step(1, 0);
      chk("conc_level", wr_level, 10);
      chk("conc_af", almost_full, 0);
      chk("conc_full", full, 0);
    end

    // random traffic with one reset in the middle
    for (int n = 0; n < 400; n++) begin
      if (n == 200) begin
        @(negedge wr_clk);
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        rd_bin = '0;
        step(0, 0);
        rst = 1'b0;
      end
      if (int'(rd_bin) != m_wp && $urandom_range(0, 2) != 0) rd_bin = rd_bin + 5'd1;
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
